nn_mem_arbiter: RTL and testbench
=================================

# nn_mem_arbiter

Shares one port of a `dpram32x32_cb` kernel or weight memory between up to `NUM_REQ` requesters of the neural-net datapath: the learn-phase loader (writes), the convolution engine and the fully-connected stage (reads). It grants the port in whole bursts, auto-increments the address within a burst and drives the RAM's active-low strobes. It returns a per-beat accept strobe and a delayed read-valid to the owner. One instance sits between the controller/datapath and each RAM port.

## Interface
- `NUM_REQ`, 3, number of requesters (2..4)
- `ADDR_W`, 5, RAM address width
- `DATA_W`, 32, RAM data width
- `MAX_BURST`, 8, maximum beats per grant (power of 2); `LEN_W = $clog2(MAX_BURST)`

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NUM_REQ  request, held until last beat accepted
- `we`  in  NUM_REQ  1 = write burst, 0 = read burst; stable while `req` high
- `addr`  in  NUM_REQ×ADDR_W  burst start address; stable while `req` high
- `len`  in  NUM_REQ×LEN_W  beats minus one; stable while `req` high
- `wdata`  in  NUM_REQ×DATA_W  write data for current beat
- `ack`  out  NUM_REQ  one-hot; beat issued to RAM this cycle
- `rvalid`  out  NUM_REQ  one-hot; `rdata` valid for that requester
- `rdata`  out  DATA_W  read data, equal to `MEM_O`
- `busy`  out  1  a burst is in progress
- `MEM_A`  out  ADDR_W  RAM address
- `MEM_CSB`, `MEM_CEB`  out  1  chip select / clock enable, active-low
- `MEM_WEB`  out  1  write enable, active-low
- `MEM_OEB`  out  1  output enable, active-low
- `MEM_I`  out  DATA_W  RAM write data
- `MEM_O`  in  DATA_W  RAM read data, valid one cycle after the read beat

## Operation
- FSM states:
  - IDLE: no owner.
  - BURST: owner issues one beat per cycle.
- IDLE:
  - If any `req` is high, pick a winner and latch its owner index, `we`, `addr` into `cur_addr`, and `len` into `beats_left`.
  - Advance the priority pointer to winner+1 mod `NUM_REQ`.
  - Next state is BURST.
  - No strobes are active in IDLE.
- BURST, owner `req` high:
  - Assert `ack[owner]`, `MEM_CSB=0`, `MEM_CEB=0`, `MEM_A=cur_addr`.
  - Write: `MEM_WEB=0`, `MEM_OEB=1`, `MEM_I=wdata[owner]`.
  - Read: `MEM_WEB=1`, `MEM_OEB=0`.
  - `cur_addr` increments mod 2^ADDR_W (31 wraps to 0).
  - `beats_left` decrements.
  - The beat with `beats_left==0` is the last one; next state is IDLE.
- BURST, owner `req` low: abort. No beat is issued, no ack, next state is IDLE.
- Read data: `rvalid[owner]` is registered one cycle after each read ack and stays correct even when the FSM has already returned to IDLE.
- The pointer is the round-robin start index. The lowest index at or after the pointer wins.
- Outputs not listed for a state take their reset values.

## Timing
- Reset values: `ack=0`, `rvalid=0`, `busy=0`, `MEM_A=0`, `MEM_CSB=MEM_CEB=MEM_WEB=MEM_OEB=1`, `MEM_I=0`, state IDLE, pointer 0.
- `rdata` follows `MEM_O` and is meaningful only while `rvalid` is high.
- Latency:
  - `req` sampled high in IDLE at cycle t gives the first `ack` at t+1.
  - A burst of `len=k` occupies cycles t+1..t+1+k.
  - Read data arrives one cycle after each ack.
- At least one IDLE cycle separates consecutive bursts, so a port is granted at most `MAX_BURST` of every `MAX_BURST+1` cycles.
- Simultaneous requests in IDLE go to the round-robin winner. The others wait with `req` held.
- A new `req` from the current owner in its last-beat cycle is treated as a fresh request in the following IDLE.
- Reset mid-burst: strobes go inactive immediately (asynchronous) and any pending `rvalid` is dropped.
- `busy` is high exactly in BURST.

## Configuration
- `NN_MEM_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index always wins, and the pointer register is removed.
- Undefined (default): round-robin as described.

## Structure
- Package `nn_mem_pkg` holds:
  - `arb_state_t` enum (IDLE, BURST)
  - defaults for `ADDR_W`, `DATA_W` and `MAX_BURST`
  - the strobe inactive constant `STB_OFF = 1'b1`
- Sub-module `nn_rr_pick` takes the request vector and pointer and returns a one-hot grant and a valid flag. It is combinational and has a fixed-priority branch under the macro.

## Test plan
- **Reset**: assert `rst` mid-run → all `MEM_*B` signals read 1, `MEM_A=0`, `ack=0`, `busy=0` without a clock edge.
- **Single write burst**: req0, we=1, addr=30, len=3 → acks on 4 consecutive cycles at `MEM_A` = 30, 31, 0, 1 with `MEM_WEB=0`.
- **Read-back**: req1 read of addr=30, len=3 → `rvalid[1]` lags each ack by 1 cycle and `rdata` equals the written words.
- **Contention**: req0, req1 and req2 all asserted with len=0 → grants in order 0, 1, 2, each followed by an IDLE cycle. With `NN_MEM_ARB_FIXED_PRIO_EN`, req0 held continuously starves req1.
- **Abort**: drop req2 after its 2nd ack of a len=5 burst → no further ack, FSM returns to IDLE, and the next requester is granted 1 cycle later.
- **Reset mid-read**: assert `rst` one cycle after a read ack → no `rvalid` pulse, and the first grant after reset goes to req0.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: shared FSM type, default widths and strobe polarity for the nn memory port arbiter.
package nn_mem_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int   ADDR_W_DEF    = 5;
   localparam int   DATA_W_DEF    = 32;
   localparam int   MAX_BURST_DEF = 8;
   localparam logic STB_OFF       = 1'b1;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/nn_mem_arbiter_if.sv
// nn_mem_arbiter_if: requester burst handshake plus the RAM pin bundle of one arbitrated port.
interface nn_mem_arbiter_if
   import nn_mem_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
);
   localparam int LEN_W = $clog2(MAX_BURST);

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             we;
   logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
   logic [NUM_REQ-1:0][LEN_W-1:0]  len;
   logic [NUM_REQ-1:0][DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]             ack;
   logic [NUM_REQ-1:0]             rvalid;
   logic [DATA_W-1:0]              rdata;
   logic                           busy;
   logic [ADDR_W-1:0]              MEM_A;
   logic                           MEM_CSB;
   logic                           MEM_CEB;
   logic                           MEM_WEB;
   logic                           MEM_OEB;
   logic [DATA_W-1:0]              MEM_I;
   logic [DATA_W-1:0]              MEM_O;

   modport master (
      output req, we, addr, len, wdata, MEM_O,
      input  ack, rvalid, rdata, busy, MEM_A, MEM_CSB, MEM_CEB, MEM_WEB, MEM_OEB, MEM_I
   );

   modport slave (
      input  req, we, addr, len, wdata, MEM_O,
      output ack, rvalid, rdata, busy, MEM_A, MEM_CSB, MEM_CEB, MEM_WEB, MEM_OEB, MEM_I
   );

endinterface

// File: rtl/nn_rr_pick.sv
// nn_rr_pick: combinational one-hot pick of the lowest requesting index at or after i_ptr, wrapping.
// With NN_MEM_ARB_FIXED_PRIO_EN the pointer is ignored and index 0 always has top priority.
module nn_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_vld
);

   assign o_vld = |i_req;

`ifdef NN_MEM_ARB_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      o_grant = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) o_grant = NUM_REQ'(1) << i;
      end
   end
`else
   int               w_sum;
   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   // Walk the requesters starting at the pointer; first hit wins.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_sum   = 0;
      w_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = int'(i_ptr) + i;
         if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
         w_idx = PTR_W'(w_sum);
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/nn_mem_arbiter.sv
// nn_mem_arbiter: grants one dpram32x32_cb port to NUM_REQ requesters in whole bursts; first ack one cycle
// after req is seen in IDLE, rvalid one cycle after each read ack. NN_MEM_ARB_FIXED_PRIO_EN: fixed priority.
module nn_mem_arbiter
   import nn_mem_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
)(
   input  logic            clk,
   input  logic            rst,
   nn_mem_arbiter_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_BURST);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [PTR_W-1:0]   r_owner;
   logic               r_we;
   logic [ADDR_W-1:0]  r_cur_addr;
   logic [LEN_W-1:0]   r_beats_left;
   logic [NUM_REQ-1:0] r_rvalid;

   logic [PTR_W-1:0]   w_ptr;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_grant_vld;
   logic [PTR_W-1:0]   w_grant_idx;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic               w_beat;
   logic               w_last;

`ifdef NN_MEM_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [PTR_W-1:0] r_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (r_state == IDLE && w_grant_vld) begin
         r_ptr <= PTR_W'(wrap_inc(int'(w_grant_idx), NUM_REQ));
      end
   end

   assign w_ptr = r_ptr;
`endif

   nn_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .i_req   (bus.req),
      .i_ptr   (w_ptr),
      .o_grant (w_grant),
      .o_vld   (w_grant_vld)
   );

   always_comb begin
      w_grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) w_grant_idx = PTR_W'(i);
      end
   end

   // A beat only issues while the owner still holds req; a dropped req aborts the burst.
   assign w_owner_oh = NUM_REQ'(1) << r_owner;
   assign w_beat     = (r_state == BURST) && bus.req[r_owner];
   assign w_last     = w_beat && (r_beats_left == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      bus.ack     = '0;
      bus.busy    = (r_state == BURST);
      bus.MEM_A   = '0;
      bus.MEM_CSB = STB_OFF;
      bus.MEM_CEB = STB_OFF;
      bus.MEM_WEB = STB_OFF;
      bus.MEM_OEB = STB_OFF;
      bus.MEM_I   = '0;
      case (r_state)
         IDLE: begin
            if (w_grant_vld) w_state_nxt = BURST;
         end
         BURST: begin
            if (!w_beat || w_last) w_state_nxt = IDLE;
            if (w_beat) begin
               bus.ack     = w_owner_oh;
               bus.MEM_CSB = ~STB_OFF;
               bus.MEM_CEB = ~STB_OFF;
               bus.MEM_A   = r_cur_addr;
               if (r_we) begin
                  bus.MEM_WEB = ~STB_OFF;
                  bus.MEM_I   = bus.wdata[r_owner];
               end else begin
                  bus.MEM_OEB = ~STB_OFF;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= '0;
         r_we         <= 1'b0;
         r_cur_addr   <= '0;
         r_beats_left <= '0;
      end else if (r_state == IDLE) begin
         if (w_grant_vld) begin
            r_owner      <= w_grant_idx;
            r_we         <= bus.we[w_grant_idx];
            r_cur_addr   <= bus.addr[w_grant_idx];
            r_beats_left <= bus.len[w_grant_idx];
         end
      end else if (w_beat) begin
         r_cur_addr   <= r_cur_addr + ADDR_W'(1);
         r_beats_left <= r_beats_left - LEN_W'(1);
      end
   end

   // Read data lands one cycle after the beat, possibly after the FSM is back in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_rvalid <= '0;
      else if (w_beat && !r_we) r_rvalid <= w_owner_oh;
      else                     r_rvalid <= '0;
   end

   assign bus.rvalid = r_rvalid;
   assign bus.rdata  = bus.MEM_O;

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// tb_nn_mem_arbiter: randomized burst rounds against a schedule-level reference model plus directed
// reset, abort and held-request scenarios; a behavioural RAM sits on the MEM_* pins.
module tb_nn_mem_arbiter;
   import nn_mem_pkg::*;

   localparam int N    = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int MB   = 8;
   localparam int LW   = 3;
   localparam int TMAX = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nn_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) bus ();

   nn_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] ram [32] = '{default: '0};

   always @(posedge clk) begin
      if (!bus.MEM_CSB && !bus.MEM_CEB) begin
         if (!bus.MEM_WEB)      ram[bus.MEM_A] <= bus.MEM_I;
         else if (!bus.MEM_OEB) bus.MEM_O      <= ram[bus.MEM_A];
      end
   end

   int            n_chk  = 0;
   int            n_pass = 0;
   int            m_ptr  = 0;
   logic [DW-1:0] mdl_mem [32] = '{default: '0};
   logic [DW-1:0] wdat [N][MB];

   logic [N-1:0]  e_ack  [TMAX];
   logic          e_busy [TMAX];
   logic [AW-1:0] e_addr [TMAX];
   logic          e_we   [TMAX];
   logic [DW-1:0] e_wd   [TMAX];
   logic [N-1:0]  e_rv   [TMAX];
   logic [DW-1:0] e_rd   [TMAX];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_wdat();
      for (int i = 0; i < N; i++)
         for (int b = 0; b < MB; b++) wdat[i][b] = $urandom;
   endtask

   // All active requesters raise req together in an idle cycle and hold it until their bursts finish.
   task automatic run_round(input logic [N-1:0] act, input logic [N-1:0] we_v,
                            input logic [N-1:0][AW-1:0] ad, input logic [N-1:0][LW-1:0] ln);
      int           order[$];
      int           t;
      int           a;
      int           b_beat[N];
      logic [N-1:0] got;
      for (int c = 0; c < TMAX; c++) begin
         e_ack[c] = '0; e_busy[c] = 1'b0; e_addr[c] = '0; e_we[c] = 1'b0;
         e_wd[c]  = '0; e_rv[c]   = '0;   e_rd[c]   = '0;
      end
      for (int k = 0; k < N; k++) begin
         int r;
`ifdef NN_MEM_ARB_FIXED_PRIO_EN
         r = k;
`else
         r = (m_ptr + k) % N;
`endif
         if (act[r]) order.push_back(r);
      end
      t = 1;
      foreach (order[j]) begin
         int r;
         r = order[j];
         for (int b = 0; b <= int'(ln[r]); b++) begin
            a = (int'(ad[r]) + b) % 32;
            e_ack[t+b]  = N'(1 << r);
            e_busy[t+b] = 1'b1;
            e_addr[t+b] = AW'(a);
            e_we[t+b]   = we_v[r];
            if (we_v[r]) begin
               mdl_mem[a] = wdat[r][b];
               e_wd[t+b]  = wdat[r][b];
            end else begin
               e_rv[t+b+1] = N'(1 << r);
               e_rd[t+b+1] = mdl_mem[a];
            end
         end
         t     = t + int'(ln[r]) + 2;
         m_ptr = (r + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         bus.req[i]   = act[i];
         bus.we[i]    = we_v[i];
         bus.addr[i]  = ad[i];
         bus.len[i]   = ln[i];
         bus.wdata[i] = wdat[i][0];
         b_beat[i]    = 0;
      end
      for (int c = 0; c < t; c++) begin
         @(negedge clk);
         got = bus.ack;
         chk("ack", got, e_ack[c]);
         chk("busy", bus.busy, e_busy[c]);
         chk("rvalid", bus.rvalid, e_rv[c]);
         if (e_rv[c] != '0) chk("rdata", bus.rdata, e_rd[c]);
         if (e_ack[c] != '0) begin
            chk("mem_a", bus.MEM_A, e_addr[c]);
            chk("mem_csb_ceb", {bus.MEM_CSB, bus.MEM_CEB}, 2'b00);
            chk("mem_web", bus.MEM_WEB, !e_we[c]);
            chk("mem_oeb", bus.MEM_OEB, e_we[c]);
            if (e_we[c]) chk("mem_i", bus.MEM_I, e_wd[c]);
         end else begin
            chk("strobes_off", {bus.MEM_CSB, bus.MEM_CEB, bus.MEM_WEB, bus.MEM_OEB}, 4'hF);
         end
         step();
         for (int i = 0; i < N; i++) begin
            if (got[i]) begin
               b_beat[i]++;
               if (b_beat[i] > int'(ln[i])) bus.req[i] = 1'b0;
               else                         bus.wdata[i] = wdat[i][b_beat[i]];
            end
         end
      end
   endtask

   task automatic rnd_round();
      logic [N-1:0]          act;
      logic [N-1:0]          wv;
      logic [N-1:0][AW-1:0]  ad;
      logic [N-1:0][LW-1:0]  ln;
      act = N'($urandom_range(1, 7));
      wv  = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
         ad[i] = AW'($urandom_range(0, 31));
         ln[i] = LW'($urandom_range(0, MB - 1));
      end
      fill_wdat();
      run_round(act, wv, ad, ln);
   endtask

   // req2 reads len=5 and drops req after its 2nd beat while req0 waits with a single-beat read.
   task automatic abort_test();
      bus.we = '0;
      bus.addr[2] = AW'(5); bus.len[2] = LW'(5);
      bus.addr[0] = AW'(9); bus.len[0] = LW'(0);
      bus.req = 3'b100;
      @(negedge clk); chk("abort_c0_ack", bus.ack, 3'b000);
      step(); bus.req[0] = 1'b1;
      @(negedge clk); chk("abort_beat1", bus.ack, 3'b100); chk("abort_beat1_a", bus.MEM_A, 5);
      step();
      @(negedge clk); chk("abort_beat2", bus.ack, 3'b100); chk("abort_beat2_a", bus.MEM_A, 6);
      step(); bus.req[2] = 1'b0;
      @(negedge clk);
      chk("abort_no_ack", bus.ack, 3'b000);
      chk("abort_busy", bus.busy, 1'b1);
      chk("abort_rvalid", bus.rvalid, 3'b100);
      chk("abort_rdata", bus.rdata, mdl_mem[6]);
      step();
      @(negedge clk); chk("abort_idle_busy", bus.busy, 1'b0); chk("abort_idle_ack", bus.ack, 3'b000);
      step();
      @(negedge clk); chk("abort_next_grant", bus.ack, 3'b001); chk("abort_next_a", bus.MEM_A, 9);
      step(); bus.req[0] = 1'b0;
      @(negedge clk); chk("abort_next_rvalid", bus.rvalid, 3'b001); chk("abort_next_rdata", bus.rdata, mdl_mem[9]);
      step();
      m_ptr = 1;
   endtask

   // Reset lands mid read beat; strobes must drop at once and the pointer must restart at 0.
   task automatic reset_test();
      bus.we = '0;
      bus.addr[0] = AW'(3); bus.len[0] = LW'(0);
      bus.addr[1] = AW'(4); bus.len[1] = LW'(0);
      bus.req = 3'b001;
      step(); bus.req[1] = 1'b1;
      @(negedge clk);
      chk("rst_pre_ack", bus.ack, 3'b001);
      chk("rst_pre_oeb", bus.MEM_OEB, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_async_strobes", {bus.MEM_CSB, bus.MEM_CEB, bus.MEM_WEB, bus.MEM_OEB}, 4'hF);
      chk("rst_async_mem_a", bus.MEM_A, 0);
      chk("rst_async_ack", bus.ack, 3'b000);
      chk("rst_async_busy", bus.busy, 1'b0);
      step();
      @(negedge clk); chk("rst_no_rvalid", bus.rvalid, 3'b000);
      step(); rst = 1'b0;
      @(negedge clk); chk("rst_release_ack", bus.ack, 3'b000);
      step();
      @(negedge clk); chk("rst_first_grant", bus.ack, 3'b001);
      step(); bus.req[0] = 1'b0;
      step();
      @(negedge clk); chk("rst_second_grant", bus.ack, 3'b010);
      step(); bus.req[1] = 1'b0;
      @(negedge clk); chk("rst_second_rvalid", bus.rvalid, 3'b010);
      step();
      m_ptr = 2;
   endtask

   // req0 and req1 both hold single-beat requests for ten cycles.
   task automatic hold_test();
      int c0;
      int c1;
      int first;
      c0 = 0;
      c1 = 0;
      first = (m_ptr == 1) ? 1 : 0;
      bus.we = '0;
      bus.addr[0] = AW'(1); bus.len[0] = LW'(0);
      bus.addr[1] = AW'(2); bus.len[1] = LW'(0);
      bus.req = 3'b011;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.ack[0]) c0++;
         if (bus.ack[1]) c1++;
         step();
      end
      bus.req = '0;
      step();
`ifdef NN_MEM_ARB_FIXED_PRIO_EN
      chk("hold_ack0", c0, 5);
      chk("hold_ack1_starved", c1, 0);
`else
      chk("hold_ack0", c0, (first == 0) ? 3 : 2);
      chk("hold_ack1", c1, (first == 1) ? 3 : 2);
      m_ptr = (first + 1) % N;
`endif
   endtask

   initial begin
      logic [N-1:0][AW-1:0] ad;
      logic [N-1:0][LW-1:0] ln;
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.len   = '0;
      bus.wdata = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_ack", bus.ack, 3'b000);
      chk("reset_rvalid", bus.rvalid, 3'b000);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_mem_a", bus.MEM_A, 0);
      chk("reset_strobes", {bus.MEM_CSB, bus.MEM_CEB, bus.MEM_WEB, bus.MEM_OEB}, 4'hF);
      chk("reset_mem_i", bus.MEM_I, 0);
      step();
      rst = 1'b0;
      step();

      // contention: three single-beat requests at once
      for (int i = 0; i < N; i++) ad[i] = AW'($urandom_range(8, 20));
      ln = '0;
      fill_wdat();
      run_round(3'b111, N'($urandom_range(0, 7)), ad, ln);

      // write burst wrapping the address space, then read it back from another requester
      ad = '0; ln = '0;
      ad[0] = AW'(30); ln[0] = LW'(3);
      fill_wdat();
      run_round(3'b001, 3'b001, ad, ln);
      ad = '0; ln = '0;
      ad[1] = AW'(30); ln[1] = LW'(3);
      fill_wdat();
      run_round(3'b010, 3'b000, ad, ln);

      abort_test();
      reset_test();
      hold_test();

      for (int r = 0; r < 40; r++) rnd_round();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
